of_interlock_ctrl: RTL
======================

# of_interlock_ctrl

Pipeline interlock controller for the operand-fetch stage. It tracks destination registers in flight in EX, MA and RW, and drives the RW→OF forwarding selects into the OF operand muxes. It also generates the IF/OF stall, EX bubble and IF/OF flush controls for load-use hazards, taken branches and multi-cycle EX operations. It sits beside the OF stage and is the sole source of `signal1/2_from_forwarding*_for_RW_OF`-style selects.

## Interface
Parameters:
- `MULTI_CYCLES`, default 4: EX occupancy in cycles of a multi-cycle (mul/div) op; legal range 2–16.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `of_valid` input 1: OF holds a valid instruction.
- `of_rs1` input 4: OF read port 1 register index (already muxed, includes ra=15).
- `of_rs2` input 4: OF read port 2 register index (already muxed, includes rd for stores).
- `of_uses_rs1` input 1: OF instruction reads port 1.
- `of_uses_rs2` input 1: OF instruction reads port 2.
- `of_rd` input 4: OF destination register (15 for call).
- `of_writes` input 1: OF instruction writes the register file (isWb).
- `of_is_ld` input 1: OF instruction is a load.
- `of_is_multi` input 1: OF instruction is multi-cycle in EX.
- `ex_branch_taken` input 1: EX resolved a taken branch this cycle.
- `fwd1_rw_of` output 1: select RW write data for OP1.
- `fwd2_rw_of` output 1: select RW write data for OP2.
- `stall_if` output 1: hold PC/IF register.
- `stall_of` output 1: hold OF pipeline register.
- `bubble_ex` output 1: load NOP into the OF/EX register.
- `flush_if_of` output 1: invalidate the IF/OF and OF contents.
- `busy` output 1: multi-cycle op occupying EX.

## Operation
- Tracker: three slots EX, MA and RW. Each slot holds {valid, rd, is_ld}, with valid meaning "writes rd".
- Issue condition: `issue = of_valid & ~stall_of & ~flush_if_of`.
- Normal advance (state IDLE):
  - EX ← OF if `issue & of_writes`, else invalid.
  - MA ← EX.
  - RW ← MA.
- Match definition: `mX(rs)` is `X.valid & X.rd==rs`.
- Forwarding:
  - `fwd1_rw_of = of_valid & of_uses_rs1 & mRW(of_rs1) & ~mEX(of_rs1) & ~mMA(of_rs1)`.
  - `fwd2_rw_of` uses the same expression with rs2.
  - Newer EX/MA producers are left to the EX-stage forwarder.
- Load-use hazard:
  - Condition: `of_valid & EX.is_ld & (mEX(of_rs1)&of_uses_rs1 | mEX(of_rs2)&of_uses_rs2)`.
  - Response: `stall_if=stall_of=bubble_ex=1` for exactly one cycle.
- Branch flush:
  - `ex_branch_taken` in IDLE sets `flush_if_of=1` and `bubble_ex=1`.
  - The OF instruction is not issued.
  - Flush has priority over load-use stall; the stall is suppressed that cycle.
- Multi-cycle FSM, states IDLE and BUSY, 4-bit counter `cnt`:
  - IDLE→BUSY: when `issue & of_is_multi`. Load `cnt = MULTI_CYCLES-1`.
  - In BUSY:
    - `busy=stall_if=stall_of=1`.
    - EX slot holds.
    - MA ← invalid (bubble).
    - RW ← MA.
    - `cnt` decrements each cycle.
  - BUSY→IDLE: when `cnt==1`. On the next cycle EX advances normally.
  - `ex_branch_taken` is ignored in BUSY, since the EX occupant is not a branch.
- Reset: all slots invalid, state IDLE, `cnt=0`. While `rst_n=0` every output is forced to 0, including `flush_if_of`.

## Timing
- All outputs are combinational from tracker state plus the OF inputs. Zero-cycle latency: an output is valid in the same cycle as its inputs.
- Tracker and FSM update on the rising `clk` edge. Reset is asynchronous assert; deassert takes effect at the first edge after release.
- Load-use stall lasts 1 cycle. On the following cycle the load is in MA, and EX forwarding resolves the hazard.
- Multi-cycle op: EX is occupied for `MULTI_CYCLES` cycles. Stalls are asserted for `MULTI_CYCLES-1` cycles, starting the cycle after issue.
- Simultaneous load-use and `ex_branch_taken`: flush wins, no stall.
- Simultaneous `of_is_multi` issue and load-use hazard: the stall wins, and the multi op issues a cycle later.
- Reset mid-BUSY: FSM returns to IDLE immediately and all slots clear.

## Configuration
- Macro: `OF_INTERLOCK_MULTI_EN`.
- Defined: the multi-cycle FSM, counter and `busy` are present as described.
- Undefined:
  - `of_is_multi` is ignored.
  - No FSM or counter logic.
  - `busy` is tied to 0.
  - Every EX op is single-cycle.

## Test plan
- Forwarding: issue `add r3` (writes r3), then two unrelated ops, then an op reading r3 on port 1. Expect `fwd1_rw_of=1` on that cycle only; `fwd2_rw_of=0`.
- Load-use: `ld r5` followed immediately by `add` reading r5 on port 2. Expect `stall_if=stall_of=bubble_ex=1` for one cycle, then 0, with no forward asserted.
- Branch flush: `ex_branch_taken=1` while OF holds `ld`-dependent `add r5`. Expect `flush_if_of=1`, `bubble_ex=1`, `stall_*=0`; EX slot invalid next cycle.
- Multi-cycle: `mul r2` with `MULTI_CYCLES=4`. Expect `busy=stall_if=stall_of=1` for 3 cycles after issue, then IDLE. MA receives 3 bubbles.
- Reset: assert `rst_n=0` during BUSY. Expect all outputs 0 immediately. After release: IDLE, no forwarding on a read of the previously pending rd.

Source files
------------

// File: rtl/of_interlock_if.sv
// Operand-fetch interlock bundle: OF decode fields and EX branch status in,
// forwarding selects and pipeline hold/kill controls out.
interface of_interlock_if;
  logic       of_valid;
  logic [3:0] of_rs1;
  logic [3:0] of_rs2;
  logic       of_uses_rs1;
  logic       of_uses_rs2;
  logic [3:0] of_rd;
  logic       of_writes;
  logic       of_is_ld;
  logic       of_is_multi;
  logic       ex_branch_taken;
  logic       fwd1_rw_of;
  logic       fwd2_rw_of;
  logic       stall_if;
  logic       stall_of;
  logic       bubble_ex;
  logic       flush_if_of;
  logic       busy;

  modport master (
    output of_valid, of_rs1, of_rs2, of_uses_rs1, of_uses_rs2, of_rd,
           of_writes, of_is_ld, of_is_multi, ex_branch_taken,
    input  fwd1_rw_of, fwd2_rw_of, stall_if, stall_of, bubble_ex,
           flush_if_of, busy
  );

  modport slave (
    input  of_valid, of_rs1, of_rs2, of_uses_rs1, of_uses_rs2, of_rd,
           of_writes, of_is_ld, of_is_multi, ex_branch_taken,
    output fwd1_rw_of, fwd2_rw_of, stall_if, stall_of, bubble_ex,
           flush_if_of, busy
  );
endinterface

// File: rtl/of_interlock_ctrl.sv
// Operand-fetch interlock controller: tracks in-flight destinations in
// EX/MA/RW, drives the RW->OF forwarding selects and the stall, bubble and
// flush controls for load-use hazards, taken branches and multi-cycle EX ops.
// Build option: define OF_INTERLOCK_MULTI_EN to include the multi-cycle
// EX FSM; without it every EX op is single-cycle and busy stays low.
//
// state  | meaning
// S_IDLE | pipeline advances normally, branches honoured
// S_BUSY | multi-cycle op holds EX, OF/IF stalled, MA fed bubbles
module of_interlock_ctrl #(
  parameter int MULTI_CYCLES = 4
) (
  input logic            clk,
  input logic            rst_n,
  of_interlock_if.slave  bus
);

  logic       r_ex_v, r_ex_ld, r_ma_v, r_rw_v;
  logic [3:0] r_ex_rd, r_ma_rd, r_rw_rd;
  logic       w_busy, w_flush, w_load_use, w_stall, w_issue;
  logic       w_ex1, w_ex2, w_ma1, w_ma2, w_rw1, w_rw2;

  assign w_ex1 = r_ex_v & (r_ex_rd == bus.of_rs1);
  assign w_ex2 = r_ex_v & (r_ex_rd == bus.of_rs2);
  assign w_ma1 = r_ma_v & (r_ma_rd == bus.of_rs1);
  assign w_ma2 = r_ma_v & (r_ma_rd == bus.of_rs2);
  assign w_rw1 = r_rw_v & (r_rw_rd == bus.of_rs1);
  assign w_rw2 = r_rw_v & (r_rw_rd == bus.of_rs2);

  // The EX occupant during BUSY is never a branch, so branch status is ignored there.
  assign w_flush    = bus.ex_branch_taken & ~w_busy;
  assign w_load_use = bus.of_valid & r_ex_ld &
                      ((w_ex1 & bus.of_uses_rs1) | (w_ex2 & bus.of_uses_rs2));
  assign w_stall    = w_busy | (w_load_use & ~w_flush);
  assign w_issue    = bus.of_valid & ~w_stall & ~w_flush;

  // Outputs are held low for the whole time reset is asserted.
  assign bus.fwd1_rw_of  = rst_n & bus.of_valid & bus.of_uses_rs1 & w_rw1 & ~w_ex1 & ~w_ma1;
  assign bus.fwd2_rw_of  = rst_n & bus.of_valid & bus.of_uses_rs2 & w_rw2 & ~w_ex2 & ~w_ma2;
  assign bus.stall_if    = rst_n & w_stall;
  assign bus.stall_of    = rst_n & w_stall;
  assign bus.bubble_ex   = rst_n & (w_flush | (w_load_use & ~w_busy));
  assign bus.flush_if_of = rst_n & w_flush;
  assign bus.busy        = rst_n & w_busy;

  // Destination tracker: shift EX->MA->RW, or hold EX and bubble MA while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v  <= 1'b0;
      r_ex_ld <= 1'b0;
      r_ex_rd <= 4'd0;
      r_ma_v  <= 1'b0;
      r_ma_rd <= 4'd0;
      r_rw_v  <= 1'b0;
      r_rw_rd <= 4'd0;
    end else if (w_busy) begin
      r_ma_v  <= 1'b0;
      r_rw_v  <= r_ma_v;
      r_rw_rd <= r_ma_rd;
    end else begin
      r_ex_v  <= w_issue & bus.of_writes;
      r_ex_ld <= w_issue & bus.of_writes & bus.of_is_ld;
      r_ex_rd <= bus.of_rd;
      r_ma_v  <= r_ex_v;
      r_ma_rd <= r_ex_rd;
      r_rw_v  <= r_ma_v;
      r_rw_rd <= r_ma_rd;
    end
  end

`ifdef OF_INTERLOCK_MULTI_EN
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  // Multi-cycle FSM state and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Enter BUSY on a multi-cycle issue; leave once the last stall cycle has run.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_issue & bus.of_is_multi) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = 4'(MULTI_CYCLES - 1);
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy = (r_state == S_BUSY);
`else
  logic w_unused_cfg;

  assign w_busy       = 1'b0;
  assign w_unused_cfg = bus.of_is_multi ^ (MULTI_CYCLES > 1);
`endif

endmodule
